hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall sequencer for the 5-stage RV32I core. Decodes the ID-stage instruction
//  (same inst[6:2] opcode classes the immediate extender uses) against EX-stage state.
//  Drives stall/flush enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Owns a data-memory wait FSM with timeout, plus stall/flush performance counters.
// PARAMETERS
//  CNT_W     32  width of perf counters stall_cnt, flush_cnt (saturating)
//  MAX_WAIT  16  dmem wait cycles before mem_timeout sets (1..2^8-1)
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  id_inst        in   32     instruction in ID stage
//  id_valid       in   1      id_inst is a real instruction (not a bubble)
//  ex_is_load     in   1      EX-stage instruction is LOAD
//  ex_rd          in   5      EX-stage destination register
//  ex_redirect    in   1      EX resolved taken BRANCH, JAL or JALR (PC redirect)
//  mem_req        in   1      MEM stage issues a load/store to dmem this cycle
//  mem_ready      in   1      dmem completes the outstanding access
//  pc_stall       out  1      hold PC
//  ifid_stall     out  1      hold IF/ID
//  ifid_flush     out  1      IF/ID <- NOP
//  idex_stall     out  1      hold ID/EX
//  idex_flush     out  1      ID/EX <- bubble
//  exmem_stall    out  1      hold EX/MEM
//  memwb_bubble   out  1      MEM/WB <- bubble (no writeback)
//  mem_timeout    out  1      sticky: dmem wait exceeded MAX_WAIT
//  stall_cnt      out  CNT_W  cycles with pc_stall=1
//  flush_cnt      out  CNT_W  cycles with ifid_flush=1
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_timeout=0, counters=0; all outputs 0 while rst_n=0.
//  Stall/flush outputs combinational from state + inputs (act in same cycle); state and counters registered.
//  Register use by opcode inst[6:2]:
//   - rs1 (inst[19:15]): all except LUI 01101, AUIPC 00101, JAL 11011.
//   - rs2 (inst[24:20]): BRANCH 11000, STORE 01000, OP 01100 only.
//   - Register x0 never hazards.
//  load_use = id_valid & ex_is_load & ex_rd!=0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
//  FSM RUN:
//   - mem_req & !mem_ready -> enter MEM_WAIT; this cycle pc/ifid/idex/exmem stall=1, memwb_bubble=1.
//   - Else if ex_redirect: ifid_flush=1, idex_flush=1; no stalls. Redirect beats load_use (stale ID).
//   - Else if load_use: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle.
//   - mem_req & mem_ready same cycle: no wait, single-cycle access.
//  FSM MEM_WAIT:
//   - pc/ifid/idex/exmem stall=1, memwb_bubble=1, no flushes; ex_redirect, load_use ignored (EX frozen).
//   - wait_cnt increments each cycle.
//   - mem_ready=1: go RUN; this cycle already uses RUN rules with mem stall removed, so a held
//     ex_redirect or load_use acts that cycle.
//   - wait_cnt reaching MAX_WAIT sets mem_timeout (sticky until reset); FSM keeps waiting.
//  wait_cnt clears on entry to MEM_WAIT.
//  Counters saturate at all-ones; counting includes wait cycles.
//  rst_n low mid-wait: immediately RUN, outputs 0.
// TESTING
//  1 LOAD x5 in EX, ID=ADD x6,x5,x1 (0x00128333) -> one cycle pc_stall=ifid_stall=idex_flush=1, stall_cnt=1.
//  2 LOAD x5 in EX, ID=LUI x5,1 / ID=ADDI x6,x0,1 -> no stall (LUI no rs; x0 ignored).
//  3 ex_redirect=1 with load_use also true -> ifid_flush=idex_flush=1, pc_stall=0, flush_cnt+1.
//  4 mem_req=1, mem_ready after 3 cycles -> stalls high 3 cycles, release on ready cycle, stall_cnt=3.
//  5 mem_req held, mem_ready low 20 cycles (MAX_WAIT=16) -> mem_timeout=1 at wait 16, stays after ready.
//  6 rst_n asserted in MEM_WAIT -> outputs 0 asynchronously, counters 0, RUN after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, redirect and dmem-wait hazards.
// Controls act in the same cycle; the dmem wait FSM, timeout flag and perf counters are registered.
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [7:0] WAIT_LIM   = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;

  logic [4:0] opc, rs1, rs2;
  logic       use_rs1, use_rs2, load_use, mem_hold;
  logic       pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_b;

  assign opc = id_inst[6:2];
  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  assign use_rs1  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign use_rs2  = (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
  assign load_use = id_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));

  // A ready beat in MEM_WAIT releases the pipe and falls through to the RUN priorities.
  assign mem_hold = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    pc_s    = 1'b0;
    ifid_s  = 1'b0;
    ifid_f  = 1'b0;
    idex_s  = 1'b0;
    idex_f  = 1'b0;
    exmem_s = 1'b0;
    memwb_b = 1'b0;
    if (mem_hold) begin
      pc_s    = 1'b1;
      ifid_s  = 1'b1;
      idex_s  = 1'b1;
      exmem_s = 1'b1;
      memwb_b = 1'b1;
    end else if (ex_redirect) begin
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else if (load_use) begin
      pc_s   = 1'b1;
      ifid_s = 1'b1;
      idex_f = 1'b1;
    end
  end

  // Gate with rst_n so every control is quiet while reset is held, whatever the inputs do.
  assign pc_stall     = rst_n & pc_s;
  assign ifid_stall   = rst_n & ifid_s;
  assign ifid_flush   = rst_n & ifid_f;
  assign idex_stall   = rst_n & idex_s;
  assign idex_flush   = rst_n & idex_f;
  assign exmem_stall  = rst_n & exmem_s;
  assign memwb_bubble = rst_n & memwb_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (pc_s && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_f && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      case (state)
        RUN: begin
          if (mem_hold) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else begin
            if (wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == WAIT_LIM) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
